cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
- Multi-stage CIC interpolator: the transmit-direction counterpart of the receive-path CIC decimator.
- Accepts low-rate signed samples through a valid/ready handshake and zero-stuffs them by R = 2^k.
- Produces one signed sample per clk cycle, sized to drive PWM or mixer/DAC logic at the system clock rate.
- DC gain is normalised to exactly 1 by a runtime arithmetic shift.

Parameters:
- IN_WIDTH, 8: input sample width, two's complement.
- OUT_WIDTH, 8: output sample width, two's complement.
- STAGES, 4: number of comb stages and number of integrator stages (N); differential delay is 1.
- ACC_WIDTH, 56: internal comb/integrator width. Must be at least IN_WIDTH + (N-1)*14 + 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- interp_log2  in  4  k, where ratio R = 2^k. Legal 1..14; 0 is treated as 1, values above 14 as 14.
- d_in  in  IN_WIDTH  signed input sample.
- d_in_valid  in  1  d_in holds a valid sample.
- d_in_ready  out  1  block takes a sample this cycle.
- d_out  out  OUT_WIDTH  signed interpolated sample.
- d_out_valid  out  1  d_out is meaningful.
- underrun  out  1  one-cycle pulse: a sample was required but none was offered.

Behaviour:
- Reset (rst=1 at an edge): phase counter, comb delays, comb output register, integrators, held sample, k_reg, d_out, d_out_valid and underrun all go to 0. d_in_ready is 0 while rst=1. This applies mid-stream too: no residual state survives.
- k_reg: loads the clamped interp_log2 on every strobe cycle (cnt==0). A ratio change mid-stream gives a transient only, never a lockup.
- Phase counter cnt:
  - counts 0..R-1 using R = 2^k_reg, then wraps to 0;
  - free-runs every cycle while rst=0;
  - never stalls.
- Strobe: a cycle is a strobe when cnt==0 and rst=0.
- Handshake:
  - d_in_ready = (cnt==0) && !rst.
  - A transfer occurs when d_in_valid && d_in_ready; the sample is captured as the held sample x.
  - On a strobe with d_in_valid=0, x keeps its previous value (zero-order hold) and underrun=1 for that cycle.
  - d_in_valid outside strobe cycles is ignored and causes no underrun.
- Comb section:
  - updates only on strobe cycles;
  - evaluated combinationally in one cycle: c0 = sign-extended x, c_i = c_(i-1) - z_i;
  - on the strobe edge, z_i <= c_(i-1) and comb_reg <= c_N.
- Zero stuffing: integrator input u = comb_reg when cnt==1, otherwise 0. This requires R >= 2, which the clamp guarantees.
- Integrators:
  - registered cascade, updated every cycle: I_1 <= I_1 + u, I_i <= I_i + I_(i-1) for i = 2..N;
  - modular (wrapping) two's-complement arithmetic at ACC_WIDTH is intentional and required.
- Output:
  - d_out <= low OUT_WIDTH bits of (I_N >>> ((N-1)*k_reg)), arithmetic shift, registered;
  - DC gain is exactly 1;
  - |d_out| never exceeds the maximum |input|, since all impulse coefficients are non-negative, so no saturation logic is needed.
- Latency: a sample accepted on cycle t first affects d_out on cycle t+N+2 (t+6 for N=4).
- d_out_valid: 0 for the first N+2 cycles after rst deasserts, then 1 every cycle until the next reset.

Test Plan:
- Impulse: N=4, k=1; rst held 2 cycles, then released. Offer 64 at the first transfer, then 0 at every later transfer. Expect d_out = 8, 32, 48, 32, 8 on consecutive cycles starting 6 cycles after the first transfer, and 0 thereafter.
- DC/step: k=2, constant d_in = 50 always valid. Expect:
  - d_in_ready high 1 cycle in 4;
  - d_out monotonically non-decreasing from 0;
  - d_out reaches exactly 50 and holds it;
  - underrun never asserts.
- Negative DC: k=3, d_in = -100 constant. Expect steady d_out = -100 (0x9C).
- Underrun: k=1, d_in = 20 valid, then d_in_valid dropped for 3 strobes. Expect:
  - underrun pulses exactly on those 3 strobe cycles;
  - d_out stays 20 (hold behaviour);
  - d_in_ready pattern unchanged.
- Clamp: interp_log2 = 0 behaves identically to 1, and interp_log2 = 15 identically to 14. Check d_in_ready spacing of 2 and 16384 cycles respectively.
- Reset mid-stream: rst pulsed 1 cycle while d_out = 50. Next cycle d_out = 0, d_out_valid = 0, underrun = 0, d_in_ready = 1. The step response then replays identically to the DC/step test.

Source files
------------

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, ratio 2^k, unity DC gain via runtime shift
module cic_interpolator #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int STAGES    = 4,
  parameter int ACC_WIDTH = 56
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           interp_log2,
  input  logic [IN_WIDTH-1:0]  d_in,
  input  logic                 d_in_valid,
  output logic                 d_in_ready,
  output logic [OUT_WIDTH-1:0] d_out,
  output logic                 d_out_valid,
  output logic                 underrun
);
  localparam int VW = $clog2(STAGES + 3);
  logic [13:0] cnt_q, cnt_d;
  logic [3:0] k_reg_q, k_reg_d, k_clamp, k_eff;
  logic signed [IN_WIDTH-1:0] x_q, x_d;
  logic signed [ACC_WIDTH-1:0] z_q [STAGES];
  logic signed [ACC_WIDTH-1:0] z_d [STAGES];
  logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d [STAGES];
  logic signed [ACC_WIDTH-1:0] c [STAGES+1];
  logic signed [ACC_WIDTH-1:0] comb_reg_q, comb_reg_d, u;
  logic [OUT_WIDTH-1:0] d_out_q, d_out_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic d_out_valid_q, d_out_valid_d;
  logic strobe;
  logic [7:0] sh;
  // Next-state: phase counter, held sample, comb (strobe rate), integrators (clk rate), output scaling
  always_comb begin
    k_clamp = (interp_log2 == 4'd0) ? 4'd1 : (interp_log2 > 4'd14) ? 4'd14 : interp_log2;
    strobe = (cnt_q == 14'd0) && !rst;
    k_eff = (cnt_q == 14'd0) ? k_clamp : k_reg_q;
    cnt_d = (cnt_q + 14'd1) & 14'((32'd1 << k_eff) - 32'd1);
    k_reg_d = strobe ? k_clamp : k_reg_q;
    x_d = (strobe && d_in_valid) ? d_in : x_q;
    c[0] = ACC_WIDTH'(x_d);
    for (int i = 0; i < STAGES; i++) begin
      c[i+1] = c[i] - z_q[i];
      z_d[i] = strobe ? c[i] : z_q[i];
    end
    comb_reg_d = strobe ? c[STAGES] : comb_reg_q;
    u = (cnt_q == 14'd1) ? comb_reg_q : '0;
    integ_d[0] = integ_q[0] + u;
    for (int i = 1; i < STAGES; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
    sh = 8'(STAGES - 1) * {4'd0, k_reg_q};
    d_out_d = OUT_WIDTH'(integ_q[STAGES-1] >>> sh);
    vcnt_d = (vcnt_q == VW'(STAGES + 2)) ? vcnt_q : vcnt_q + VW'(1);
    d_out_valid_d = vcnt_q >= VW'(STAGES + 1);
  end
  // State registers; reset clears every stage so no residue survives a mid-stream reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      k_reg_q <= '0;
      x_q <= '0;
      comb_reg_q <= '0;
      d_out_q <= '0;
      vcnt_q <= '0;
      d_out_valid_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        z_q[i] <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      k_reg_q <= k_reg_d;
      x_q <= x_d;
      comb_reg_q <= comb_reg_d;
      d_out_q <= d_out_d;
      vcnt_q <= vcnt_d;
      d_out_valid_q <= d_out_valid_d;
      for (int i = 0; i < STAGES; i++) begin
        z_q[i] <= z_d[i];
        integ_q[i] <= integ_d[i];
      end
    end
  end
  assign d_in_ready = strobe;
  assign underrun = strobe && !d_in_valid;
  assign d_out = d_out_q;
  assign d_out_valid = d_out_valid_q;
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: scoreboard bench, convolution reference model of the CIC interpolator
module tb_cic_interpolator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] interp_log2 = 4'd1;
  logic [7:0] d_in = 8'd0;
  logic d_in_valid = 1'b0;
  logic d_in_ready, d_out_valid, underrun;
  logic [7:0] d_out;
  int n_cmp = 0;
  int n_bad = 0;
  int urun_cnt = 0;
  int rdy_cnt = 0;
  typedef struct { int pos; longint x; } smp_t;
  smp_t hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  longint h[];
  longint xh;
  int kk, rr, sh, hl, cyc;
  int imp[7] = '{8, 32, 48, 32, 8, 0, 0};
  int trace[40];

  always #5 clk = ~clk;

  cic_interpolator dut (
    .clk(clk), .rst(rst), .interp_log2(interp_log2),
    .d_in(d_in), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
    .d_out(d_out), .d_out_valid(d_out_valid), .underrun(underrun)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // Impulse response of N=4 cascaded length-R boxcars, built by running sums
  task automatic set_k(input int k);
    longint g[];
    kk = (k == 0) ? 1 : (k > 14) ? 14 : k;
    rr = 1 << kk;
    sh = 3 * kk;
    hl = 4 * (rr - 1) + 1;
    h = new[hl];
    g = new[hl];
    foreach (h[i]) h[i] = (i == 0) ? 1 : 0;
    repeat (4) begin
      for (int n = 0; n < hl; n++)
        g[n] = ((n > 0) ? g[n-1] : 0) + h[n] - ((n >= rr) ? h[n-rr] : 0);
      h = g;
    end
  endtask

  task automatic do_reset(input int n, input int k);
    rst = 1'b1;
    d_in_valid = 1'b0;
    interp_log2 = 4'(k);
    repeat (n - 1) begin
      @(posedge clk);
      #3;
      chk("rst_ready", d_in_ready, 0);
      chk("rst_valid", d_out_valid, 0);
      chk("rst_dout", $signed(d_out), 0);
      chk("rst_underrun", underrun, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    exp_q.delete();
    hist.delete();
    xh = 0;
    set_k(k);
  endtask

  // One clk cycle: drive inputs, predict d_out six cycles ahead, check handshake outputs
  task automatic step(input logic v, input logic [7:0] dat);
    bit stb;
    longint sum = 0;
    d_in = dat;
    d_in_valid = v;
    stb = (cyc % rr) == 0;
    if (stb && v) xh = longint'($signed(dat));
    if (stb) hist.push_back('{cyc, xh});
    foreach (hist[i])
      if (cyc - hist[i].pos < hl) sum += hist[i].x * h[cyc - hist[i].pos];
    while (hist.size() > 0 && cyc + 1 - hist[0].pos >= hl) void'(hist.pop_front());
    exp_q.push_back(8'(sum >>> sh));
    #2;
    chk("d_in_ready", d_in_ready, stb);
    chk("underrun", underrun, stb && !v);
    chk("d_out_valid", d_out_valid, cyc >= 6);
    if (cyc < 6) chk("d_out_pre", $signed(d_out), 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a valid sample
  always @(negedge clk) begin
    if (d_out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard at cycle %0d: got output %0d, want none pending", cyc, $signed(d_out));
      end else begin
        mon_e = exp_q.pop_front();
        chk("d_out", $signed(d_out), $signed(mon_e));
      end
    end
    if (underrun) urun_cnt++;
    if (d_in_ready) rdy_cnt++;
  end

  initial begin
    int base, prev;
    do_reset(2, 1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i == 0) ? 8'd64 : 8'd0);
      if (cyc >= 6 && cyc <= 12) chk("impulse", $signed(d_out), imp[cyc-6]);
    end
    do_reset(1, 2);
    base = urun_cnt;
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'd50);
      trace[i] = $signed(d_out);
      chk("step_monotonic", $signed(d_out) >= prev, 1);
      prev = $signed(d_out);
    end
    chk("step_final", $signed(d_out), 50);
    chk("step_underrun", urun_cnt - base, 0);
    do_reset(1, 2);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'd50);
      chk("step_replay", $signed(d_out), trace[i]);
    end
    do_reset(1, 3);
    for (int i = 0; i < 80; i++) step(1'b1, 8'h9C);
    chk("neg_dc_final", $signed(d_out), -100);
    do_reset(1, 1);
    base = urun_cnt;
    for (int i = 0; i < 46; i++) begin
      step((i < 20 || i >= 26) ? 1'b1 : 1'b0, 8'd20);
      if (cyc >= 16) chk("underrun_hold", $signed(d_out), 20);
    end
    chk("underrun_count", urun_cnt - base, 3);
    for (int k = 0; k < 4; k++) begin
      do_reset(1, k);
      for (int i = 0; i < 250; i++)
        step($urandom_range(0, 3) != 0, 8'($urandom));
    end
    do_reset(1, 15);
    base = rdy_cnt;
    for (int i = 0; i < 2 * 16384 + 8; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom));
    chk("clamp14_ready_count", rdy_cnt - base, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
